// File: rtl/ctrl_pkg.sv
// Control-unit shared types: instruction memory geometry, the packed
// allocation instruction word and the loader state encoding.
package ctrl;

    localparam int unsigned INSTRUCTION_MEMORY_SIZE = 32;

    typedef logic [$clog2(INSTRUCTION_MEMORY_SIZE)-1:0] instr_pointer_t;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [15:0] size;
        logic [31:0] base;
    } allocInstr_s;

    localparam int unsigned ALLOC_INSTR_WIDTH = $bits(allocInstr_s);
    localparam int unsigned ALLOC_INSTR_BYTES = 7;

    typedef enum logic [1:0] {L_IDLE, L_LOAD, L_DONE, L_ERR} loaderState_e;

endpackage

// File: rtl/alloc_instr_loader_if.sv
// Host byte stream plus instruction memory write port of the loader.
interface alloc_instr_loader_if;
    import ctrl::*;

    logic [7:0]     s_data;
    logic           s_valid;
    logic           s_ready;
    logic           imem_we;
    instr_pointer_t imem_addr;
    allocInstr_s    imem_wdata;

    modport master (
        output s_data, s_valid,
        input  s_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  s_data, s_valid,
        output s_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/alloc_byte_packer.sv
// Packs 7 little-endian bytes into one 52-bit allocation instruction.
// The 7th byte contributes only its low nibble; a non-zero high nibble is a
// format error and the word is not reported as complete.
module alloc_byte_packer
    import ctrl::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        word_done,
    output logic        pad_err,
    output allocInstr_s word
);

    logic [2:0]                   idx;
    logic [ALLOC_INSTR_WIDTH-1:0] asm_q;
    logic                         last_byte;

    // Classify the incoming byte: final byte of a word, clean or padded badly
    always_comb begin
        last_byte = in_valid && (idx == 3'(ALLOC_INSTR_BYTES - 1));
        pad_err   = last_byte && (in_data[7:4] != '0);
        word_done = last_byte && !pad_err;
    end

    // Byte index and assembly register
    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= '0;
            asm_q <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (in_valid) begin
            if (last_byte) begin
                asm_q[51:48] <= in_data[3:0];
                idx          <= '0;
            end else begin
                for (int unsigned k = 0; k < ALLOC_INSTR_BYTES - 1; k++) begin
                    if (idx == 3'(k)) asm_q[8*k +: 8] <= in_data;
                end
                idx <= idx + 3'd1;
            end
        end
    end

    assign word = allocInstr_s'(asm_q);

endmodule

// File: rtl/alloc_instr_loader.sv
// Loads a length-prefixed byte program into the control unit's instruction
// memory, one 52-bit instruction per 7 bytes, starting at address 0.
module alloc_instr_loader
    import ctrl::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    alloc_instr_loader_if.slave  bus,
    output logic [5:0]           prog_len,
    output logic                 prog_valid,
    output logic                 busy,
    output logic                 err
);

    loaderState_e   state, state_d;
    instr_pointer_t ptr;
    logic [5:0]     n_q;
    logic           we_q;
    logic           accept, hdr_ok, start, load_byte, last_word;
    logic           word_done, pad_err;
    allocInstr_s    word;

    alloc_byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear || start),
        .in_valid  (load_byte),
        .in_data   (bus.s_data),
        .word_done (word_done),
        .pad_err   (pad_err),
        .word      (word)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= L_IDLE;
        else     state <= state_d;
    end

    // Handshake, header decode and next-state selection
    always_comb begin
        state_d     = state;
        bus.s_ready = !(clear || rst);
        accept      = bus.s_valid && bus.s_ready;
        hdr_ok      = (bus.s_data != '0) && (bus.s_data <= 8'(INSTRUCTION_MEMORY_SIZE));
        start       = accept && hdr_ok && ((state == L_IDLE) || (state == L_DONE));
        load_byte   = accept && (state == L_LOAD);
        last_word   = ({1'b0, ptr} == (n_q - 6'd1));
        case (state)
            L_IDLE, L_DONE: if (accept) state_d = hdr_ok ? L_LOAD : L_ERR;
            L_LOAD: begin
                if (pad_err)                     state_d = L_ERR;
                else if (word_done && last_word) state_d = L_DONE;
            end
            default: state_d = state;
        endcase
        if (clear) state_d = L_IDLE;
    end

    // Word pointer, program length/validity and the registered write strobe.
    // The pointer advances on the write cycle of every word except the last,
    // so a 32-word program leaves it at 31 rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ptr        <= '0;
            n_q        <= '0;
            we_q       <= 1'b0;
            prog_len   <= '0;
            prog_valid <= 1'b0;
        end else begin
            we_q <= word_done;
            if (start) begin
                n_q        <= bus.s_data[5:0];
                ptr        <= '0;
                prog_valid <= 1'b0;
            end
            if (we_q && (state == L_LOAD)) ptr <= ptr + 1'b1;
            if (word_done && last_word) begin
                prog_valid <= 1'b1;
                prog_len   <= n_q;
            end
            if (state_d == L_ERR) prog_valid <= 1'b0;
        end
    end

    assign bus.imem_we    = we_q && !clear;
    assign bus.imem_addr  = ptr;
    assign bus.imem_wdata = word;
    assign busy           = (state == L_LOAD);
    assign err            = (state == L_ERR);

endmodule

// File: tb/tb_alloc_instr_loader.sv
// Randomized self-checking bench for alloc_instr_loader.
module tb_alloc_instr_loader;
    import ctrl::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic [5:0] prog_len;
    logic       prog_valid, busy, err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        logic [4:0]  a;
        logic [51:0] d;
        logic        pv;
        logic [5:0]  len;
    } wr_t;

    wr_t        wq[$];
    logic [7:0] pay[$];

    alloc_instr_loader_if bus ();

    alloc_instr_loader dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .bus        (bus),
        .prog_len   (prog_len),
        .prog_valid (prog_valid),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Write monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1)
            wq.push_back('{a: bus.imem_addr, d: bus.imem_wdata, pv: prog_valid, len: prog_len});
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    // Reference: instruction w of the current payload (payload excludes header)
    function automatic logic [51:0] ref_word(input int unsigned w);
        logic [51:0] r = '0;
        for (int unsigned k = 0; k < 6; k++)
            r = r | (52'(pay[7*w + k]) << (8*k));
        r = r | (52'(pay[7*w + 6] & 8'h0F) << 48);
        return r;
    endfunction

    // Drive one byte at a negedge, wait for its acceptance at the next posedge
    task automatic send_byte(input logic [7:0] b, input int unsigned max_gap);
        int unsigned g = (max_gap == 0) ? 0 : $urandom_range(max_gap, 0);
        int unsigned t = 0;
        bus.s_valid = 1'b0;
        repeat (g) @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        #1;
        while (bus.s_ready !== 1'b1 && t < 16) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 16) begin
            checks++; errors++;
            $display("FAIL send_timeout: s_ready=%b required 1", bus.s_ready);
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    // Random payload of n well-formed instructions
    task automatic make_payload(input int unsigned n);
        pay.delete();
        for (int unsigned i = 0; i < 7*n; i++)
            pay.push_back((i % 7 == 6) ? 8'($urandom_range(15, 0)) : 8'($urandom_range(255, 0)));
    endtask

    task automatic send_payload(input int unsigned max_gap);
        foreach (pay[i]) send_byte(pay[i], max_gap);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.s_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        wq.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b want 1", bus.s_ready); end
        checks++; if (bus.imem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", bus.imem_we); end
        checks++; if (bus.imem_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", bus.imem_addr); end
        checks++; if (bus.imem_wdata !== 52'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", bus.imem_wdata); end
        checks++; if ({prog_len, prog_valid, busy, err} !== 9'd0) begin errors++;
            $display("FAIL reset_status: len=%0d pv=%b busy=%b err=%b want all 0", prog_len, prog_valid, busy, err); end
    endtask

    task automatic test_single();
        pay.delete();
        pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h0A};
        wq.delete();
        send_byte(8'h01, 0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        send_payload(0);
        repeat (3) @(negedge clk);
        checks++; if (wq.size() != 1) begin errors++; $display("FAIL single_count: got %0d want 1", wq.size()); end
        else begin
            checks++; if (wq[0].a !== 5'd0 || wq[0].d !== 52'hA_6655_4433_2211) begin errors++;
                $display("FAIL single_write: addr=%0d data=%h want 0 %h", wq[0].a, wq[0].d, 52'hA_6655_4433_2211); end
            checks++; if (wq[0].pv !== 1'b1 || wq[0].len !== 6'd1) begin errors++;
                $display("FAIL single_pv_at_we: pv=%b len=%0d want 1 1", wq[0].pv, wq[0].len); end
        end
        checks++; if (prog_valid !== 1'b1 || prog_len !== 6'd1 || busy !== 1'b0) begin errors++;
            $display("FAIL single_final: pv=%b len=%0d busy=%b want 1 1 0", prog_valid, prog_len, busy); end
    endtask

    task automatic test_full();
        int unsigned bad = 0;
        pulse_clear();
        make_payload(32);
        send_byte(8'h20, 2);
        send_payload(2);
        repeat (3) @(negedge clk);
        checks++; if (wq.size() != 32) begin errors++; $display("FAIL full_count: got %0d want 32", wq.size()); end
        else begin
            for (int unsigned i = 0; i < 32; i++)
                if (wq[i].a !== 5'(i) || wq[i].d !== ref_word(i)) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL full_words: %0d words wrong, want 0", bad); end
            checks++; if (wq[31].pv !== 1'b1 || wq[30].pv !== 1'b0) begin errors++;
                $display("FAIL full_pv_timing: pv@30=%b pv@31=%b want 0 1", wq[30].pv, wq[31].pv); end
        end
        checks++; if (prog_valid !== 1'b1 || prog_len !== 6'd32 || err !== 1'b0) begin errors++;
            $display("FAIL full_final: pv=%b len=%0d err=%b want 1 32 0", prog_valid, prog_len, err); end
    endtask

    task automatic test_bad_header();
        logic [7:0] hdrs[2];
        hdrs[0] = 8'h00; hdrs[1] = 8'h21;
        foreach (hdrs[h]) begin
            pulse_clear();
            send_byte(hdrs[h], 0);
            checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++;
                $display("FAIL badhdr_err_%0h: err=%b busy=%b want 1 0", hdrs[h], err, busy); end
            send_byte(8'h01, 0);
            make_payload(1);
            send_payload(1);
            repeat (3) @(negedge clk);
            checks++; if (wq.size() != 0 || err !== 1'b1 || bus.s_ready !== 1'b1) begin errors++;
                $display("FAIL badhdr_discard_%0h: writes=%0d err=%b rdy=%b want 0 1 1", hdrs[h], wq.size(), err, bus.s_ready); end
            pulse_clear();
            checks++; if (err !== 1'b0 || prog_len !== 6'd0 || prog_valid !== 1'b0) begin errors++;
                $display("FAIL badhdr_clear_%0h: err=%b len=%0d pv=%b want 0 0 0", hdrs[h], err, prog_len, prog_valid); end
            make_payload(1);
            send_byte(8'h01, 0);
            send_payload(0);
            repeat (2) @(negedge clk);
            checks++; if (wq.size() != 1 || wq[0].a !== 5'd0 || wq[0].d !== ref_word(0)) begin errors++;
                $display("FAIL badhdr_idle_%0h: writes=%0d want 1 at addr 0", hdrs[h], wq.size()); end
        end
    endtask

    task automatic test_pad_error();
        pulse_clear();
        make_payload(2);
        pay[13] = 8'h1F;
        send_byte(8'h02, 0);
        send_payload(1);
        send_byte(8'h05, 0);
        repeat (3) @(negedge clk);
        checks++; if (wq.size() != 1) begin errors++; $display("FAIL pad_count: got %0d want 1", wq.size()); end
        else begin
            checks++; if (wq[0].a !== 5'd0 || wq[0].d !== ref_word(0)) begin errors++;
                $display("FAIL pad_word0: addr=%0d data=%h want 0 %h", wq[0].a, wq[0].d, ref_word(0)); end
        end
        checks++; if (err !== 1'b1 || prog_valid !== 1'b0) begin errors++;
            $display("FAIL pad_status: err=%b pv=%b want 1 0", err, prog_valid); end
    endtask

    task automatic test_clear_mid();
        pulse_clear();
        make_payload(2);
        send_byte(8'h03, 0);
        for (int unsigned i = 0; i < 10; i++) send_byte(pay[i], 0);
        bus.s_valid = 1'b1;
        bus.s_data  = pay[10];
        clear = 1'b1;
        #1;
        checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL clr_ready: got %b want 0", bus.s_ready); end
        @(negedge clk);
        clear = 1'b0;
        bus.s_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (wq.size() != 1 || busy !== 1'b0 || prog_len !== 6'd0) begin errors++;
            $display("FAIL clr_state: writes=%0d busy=%b len=%0d want 1 0 0", wq.size(), busy, prog_len); end
        wq.delete();
        make_payload(1);
        send_byte(8'h01, 0);
        send_payload(0);
        repeat (2) @(negedge clk);
        checks++; if (wq.size() != 1 || wq[0].a !== 5'd0 || wq[0].d !== ref_word(0) || prog_len !== 6'd1) begin errors++;
            $display("FAIL clr_reload: writes=%0d len=%0d want 1 write at 0, len 1", wq.size(), prog_len); end
    endtask

    task automatic test_back_to_back();
        pulse_clear();
        make_payload(2);
        send_byte(8'h02, 0);
        send_payload(0);
        checks++; if (prog_valid !== 1'b1 || prog_len !== 6'd2) begin errors++;
            $display("FAIL b2b_first: pv=%b len=%0d want 1 2", prog_valid, prog_len); end
        make_payload(1);
        send_byte(8'h01, 0);
        checks++; if (prog_valid !== 1'b0) begin errors++; $display("FAIL b2b_pv_drop: got %b want 0", prog_valid); end
        send_payload(0);
        repeat (2) @(negedge clk);
        checks++; if (wq.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", wq.size()); end
        else begin
            checks++; if (wq[2].a !== 5'd0 || wq[2].d !== ref_word(0) || wq[2].pv !== 1'b1 || wq[2].len !== 6'd1) begin errors++;
                $display("FAIL b2b_write: addr=%0d pv=%b len=%0d want 0 1 1", wq[2].a, wq[2].pv, wq[2].len); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_bad_header();
        test_pad_error();
        test_clear_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
